seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Downstream display stage for the auto-counter designs. Holds a 4-digit BCD value, scans it onto the board's common-anode 4-digit seven-segment display, and applies leading-zero blanking, decimal points and inter-digit dead time. Producers update the value with a one-cycle load strobe. The new value is applied only at a frame boundary, so a digit never tears mid-frame.

## Interface
- DIGIT_TICKS, 200000: clock cycles per digit slot (4 ms at 50 MHz); legal range ≥ GAP_TICKS+2.
- GAP_TICKS, 2000: cycles at the start of each slot with all anodes off (anti-ghosting).
- LZB_EN, 1: 1 enables leading-zero blanking; 0 shows every digit.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures bcd_in and dp_in.
- bcd_in  in  16  four BCD digits; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- dp_in  in  4  decimal point per digit, active-high, same digit order.
- sun  out  4  anode selects, active-low; sun[k] low lights digit k.
- seven  out  8  {dp, g, f, e, d, c, b, a}, active-low.
- frame_tick  out  1  one-cycle pulse each time the display register is (re)loaded at a frame boundary.

## Operation
- Scan state: cnt runs 0..DIGIT_TICKS-1. idx runs 0..3 and advances when cnt wraps. idx 3→0 is the frame boundary.
- Pending register:
  - load=1 captures bcd_in/dp_in into pending and sets pend_v.
  - A later load before the boundary overwrites pending. Last load wins.
- Display register update, on the boundary edge only:
  - If load=1 in the boundary cycle, disp takes bcd_in/dp_in directly (bypass).
  - Otherwise, if pend_v=1, disp takes pending.
  - pend_v clears on that edge in either case.
  - frame_tick pulses on every boundary edge.
- Gap: while cnt < GAP_TICKS, sun=4'b1111 and seven=8'hFF.
- Active part of slot: sun has only bit idx low; seven = decode(disp digit idx) with bit7 = ~dp[idx].
- Decode:
  - 0–9 use the codebase table (e.g. 0 → 7'b1000000, 8 → 7'b0000000).
  - Codes A–F display a dash, 7'b0111111.
- Leading-zero blanking (LZB_EN=1): digit k (k=1..3) is blanked when it and every higher digit are 0.
  - Blanked means sun[k]=1, seven=8'hFF, and the dp is suppressed too.
  - Digit 0 is never blanked.
  - A nonzero digit, including A–F, stops blanking for all lower digits.
- Reset (rst=0, asynchronous): cnt=0, idx=0, disp=0, dp=0, pending=0, pend_v=0, sun=4'b1111, seven=8'hFF, frame_tick=0.
- After reset release, the first frame displays "0" on digit 0 only.

## Timing
- sun, seven and frame_tick are registered; they reflect the (cnt, idx, disp) state of the previous cycle.
- Slot length is exactly DIGIT_TICKS cycles; frame length is 4·DIGIT_TICKS.
- Digit k is lit for DIGIT_TICKS−GAP_TICKS consecutive cycles per frame.
- Load-to-display latency:
  - Minimum is 1 cycle, when load coincides with the boundary.
  - Maximum is 4·DIGIT_TICKS cycles.
  - The first lit digit after an update is digit 0, one GAP_TICKS gap after the boundary.
- Reset asserted mid-slot: outputs blank immediately (asynchronous), and the pending load is discarded.
- Reset release: scanning restarts at idx 0, cnt 0.
- At most one anode is ever low in any cycle, including the cycles around a boundary.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 8'hFF.
  - SEG_DASH = 7'b0111111.
  - The 10 digit segment constants.
  - Digit index type, 2 bits.
- Sub-module seg_decode: combinational BCD → 7-segment using the seg_pkg constants. It is instantiated once and fed from the idx mux.
- Top level holds the scan counters, the pending/disp registers, the blanking logic and the output registers.

## Test plan
All scenarios use DIGIT_TICKS=8, GAP_TICKS=2.
1. Reset → sun=1111, seven=FF; after release, in the first frame only sun=1110 lights, with seven=8'hC0 (digit "0"), for 6 of every 32 cycles.
2. load bcd_in=16'h0042, dp_in=0 mid-frame → unchanged until the boundary, then frame_tick; digits 0/1 show "2"/"4" (seven=A4/99); sun[2], sun[3] stay 1.
3. Two loads (16'h1234, then 16'h0007) in the same frame → the next frame shows only 0007 with LZB, and 1234 never appears.
4. load coincides with the boundary cycle, bcd_in=16'h0100 → the frame that starts at that boundary shows "100": digit 1 shows 0 (seven=C0) and is not blanked.
5. bcd_in=16'h00A0, dp_in=4'b0010 → digit 1 shows the dash with dp, seven=8'h3F; digit 0 shows C0; digits 2–3 are blanked.
6. Assert rst for 1 cycle mid-slot with a load pending → outputs go blank asynchronously, the pending load is lost, and display returns to "0".

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low {g, f, e, d, c, b, a} for a common-anode display.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to seven-segment decode.
// Non-decimal codes (A-F) render as a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking,
// decimal points, inter-digit dead time and tear-free frame-boundary updates.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 200000,
    parameter int GAP_TICKS   = 2000,
    parameter bit LZB_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  sun,
    output logic [7:0]  seven,
    output logic        frame_tick
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_TICKS);

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic [15:0]   pend_bcd;
    logic [3:0]    pend_dp;
    logic          pend_v;
    logic [15:0]   disp_bcd;
    logic [3:0]    disp_dp;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    blank_mask;
    logic          run_zero;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign boundary  = slot_end && (idx == 2'd3);
    assign cur_digit = disp_bcd[{idx, 2'b00} +: 4];

    // Walk from the most significant digit down; blanking stops at the first nonzero code.
    always_comb begin
        run_zero   = 1'b1;
        blank_mask = '0;
        for (int k = 3; k >= 0; k--) begin
            run_zero      = run_zero & (disp_bcd[k*4 +: 4] == 4'd0);
            blank_mask[k] = LZB_EN && (k != 0) && run_zero;
        end
    end

    seg_decode u_decode (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_v     <= 1'b0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            sun        <= 4'b1111;
            seven      <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end

            // A load in the boundary cycle bypasses pending so it shows in the frame starting now.
            if (boundary) begin
                if (load) begin
                    disp_bcd <= bcd_in;
                    disp_dp  <= dp_in;
                end else if (pend_v) begin
                    disp_bcd <= pend_bcd;
                    disp_dp  <= pend_dp;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
                pend_v   <= 1'b1;
            end

            frame_tick <= boundary;

            if ((cnt < CNT_GAP) || blank_mask[idx]) begin
                sun   <= 4'b1111;
                seven <= SEG_BLANK;
            end else begin
                sun   <= ~(4'b0001 << idx);
                seven <= {~disp_dp[idx], cur_seg};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver: a frame-level model queues the
// value each frame must show; a monitor checks every output cycle against it.
module tb_seg_scan_driver;

    localparam int D = 8;
    localparam int G = 2;
    localparam int F = 4 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  sun;
    logic [7:0]  seven;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
    } frame_t;

    frame_t exp_q[$];

    // Active-low glyphs {g..a}: 0-9 digits, A-F dash.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGIT_TICKS (D),
        .GAP_TICKS   (G),
        .LZB_EN      (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .sun        (sun),
        .seven      (seven),
        .frame_tick (frame_tick)
    );

    // Frame-level reference: last load since the previous boundary wins; a boundary
    // queues the value displayed for the whole following frame.
    int unsigned t = 0;
    logic [15:0] nxt_v = '0, cur_v = '0;
    logic [3:0]  nxt_dp = '0, cur_dp = '0;
    bit          have = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            t = 0;
            have = 1'b0;
            cur_v = '0;
            cur_dp = '0;
            exp_q.delete();
        end else begin
            if (load) begin
                nxt_v = bcd_in;
                nxt_dp = dp_in;
                have = 1'b1;
            end
            if (t % F == F - 1) begin
                if (have) begin
                    cur_v = nxt_v;
                    cur_dp = nxt_dp;
                end
                have = 1'b0;
                exp_q.push_back('{cur_v, cur_dp});
            end
            t++;
        end
    end

    function automatic void expect_at(input logic [15:0] v, input logic [3:0] dp, input int p,
                                      output logic [3:0] es, output logic [7:0] ev);
        int slot;
        int off;
        es = 4'hF;
        ev = 8'hFF;
        if (p < 0) return;
        slot = (p % F) / D;
        off  = p % D;
        if (off < G) return;
        if (slot > 0 && (v >> (4 * slot)) == 16'd0) return;
        es[slot] = 1'b0;
        ev = {~dp[slot], glyph[v[4*slot +: 4]]};
    endfunction

    int     p = -1;
    frame_t cur_f = '{16'h0, 4'h0};

    always @(negedge clk) begin
        logic [3:0] es;
        logic [7:0] ev;
        logic       et;
        if (!rst) begin
            checks++;
            if (sun !== 4'hF || seven !== 8'hFF || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_blank: got sun=%b seven=%h tick=%b, want sun=1111 seven=ff tick=0",
                         sun, seven, frame_tick);
            end
            p = -1;
            cur_f = '{16'h0, 4'h0};
        end else begin
            expect_at(cur_f.v, cur_f.dp, p, es, ev);
            et = (p == F - 1);
            checks++;
            if (sun !== es || seven !== ev || frame_tick !== et) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL scan p=%0d frame=%h/%b: got sun=%b seven=%h tick=%b, want sun=%b seven=%h tick=%b",
                             p, cur_f.v, cur_f.dp, sun, seven, frame_tick, es, ev, et);
            end
            p++;
            if (frame_tick) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_queue: got frame_tick=1 with no frame expected, want frame_tick=0");
                end else begin
                    cur_f = exp_q.pop_front();
                end
                p = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1;
        bcd_in = v;
        dp_in = d;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_boundary();
        int k;
        k = 0;
        while (t % F != F - 1) begin
            tick(1);
            k++;
            if (k > 2 * F) begin
                errors++;
                $display("FAIL boundary_wait: got no boundary in %0d cycles, want one within %0d", k, F);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2 * F);

        tick(5);
        do_load(16'h0042, 4'b0000);
        tick(2 * F);

        tick(3);
        do_load(16'h1234, 4'b0000);
        tick(4);
        do_load(16'h0007, 4'b0000);
        tick(2 * F);

        wait_boundary();
        do_load(16'h0100, 4'b0000);
        tick(2 * F);

        do_load(16'h00A0, 4'b0010);
        tick(2 * F);

        // Pending load, then a short asynchronous reset while digit 0 is lit.
        wait_boundary();
        tick(1);
        do_load(16'h5678, 4'hF);
        tick(3);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (sun !== 4'hF || seven !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got sun=%b seven=%h tick=%b, want sun=1111 seven=ff tick=0",
                     sun, seven, frame_tick);
        end
        tick(1);
        rst = 1'b1;
        tick(2 * F);

        for (int i = 0; i < 40; i++) begin
            for (int n = 0; n < 4; n++)
                v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                wait_boundary();
            end else begin
                tick($urandom_range(1, 40));
            end
            do_load(v, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0)
                do_load(16'($urandom), 4'($urandom_range(0, 15)));
        end
        tick(2 * F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
